// File: rtl/multi_phase_controller.sv
// multi_phase_controller: fixed-time multi-phase signal sequencer with skip, hold and clearance
module multi_phase_controller #(
  parameter int NUM_PHASES = 4,
  parameter int TW = 7,
  parameter int PW = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  hold,
  input  logic [TW-1:0]         green_time,
  input  logic [TW-1:0]         yellow_time,
  input  logic [TW-1:0]         allred_time,
  input  logic [NUM_PHASES-1:0] skip_mask,
  output logic [PW-1:0]         active_phase,
  output logic [1:0]            sub_state,
  output logic [TW-1:0]         time_left,
  output logic [NUM_PHASES-1:0] lamp_green,
  output logic [NUM_PHASES-1:0] lamp_yellow,
  output logic                  phase_start
);
  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;
  state_t state;
  logic [PW-1:0] nxt;
  logic [PW-1:0] idx;
  logic [NUM_PHASES-1:0] one_cur;
  logic [NUM_PHASES-1:0] one_nxt;
  assign sub_state = state;
  assign one_cur = NUM_PHASES'(1) << active_phase;
  assign one_nxt = NUM_PHASES'(1) << nxt;
  function automatic logic [TW-1:0] ld(input logic [TW-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction
  // nearest unmasked phase after the current one (current itself last); plain +1 when all masked
  always_comb begin
    nxt = PW'((int'(active_phase) + 1) % NUM_PHASES);
    idx = '0;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      idx = PW'((int'(active_phase) + k) % NUM_PHASES);
      if (!skip_mask[idx]) nxt = idx;
    end
  end
  // sequencer: enable/reset park in IDLE, hold freezes, otherwise count down and advance
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state        <= IDLE;
      active_phase <= '0;
      time_left    <= '0;
      lamp_green   <= '0;
      lamp_yellow  <= '0;
      phase_start  <= 1'b0;
    end else if (state == IDLE) begin
      state        <= GREEN;
      active_phase <= '0;
      time_left    <= ld(green_time);
      lamp_green   <= NUM_PHASES'(1);
      lamp_yellow  <= '0;
      phase_start  <= 1'b1;
    end else if (hold) begin
      phase_start  <= 1'b0;
    end else if (time_left != '0) begin
      time_left    <= time_left - 1'b1;
      phase_start  <= 1'b0;
    end else if (state == GREEN) begin
      state        <= YELLOW;
      time_left    <= ld(yellow_time);
      lamp_green   <= '0;
      lamp_yellow  <= one_cur;
      phase_start  <= 1'b0;
    end else if (state == YELLOW && allred_time != '0) begin
      state        <= ALLRED;
      time_left    <= allred_time - 1'b1;
      lamp_yellow  <= '0;
      phase_start  <= 1'b0;
    end else begin
      state        <= GREEN;
      active_phase <= nxt;
      time_left    <= ld(green_time);
      lamp_green   <= one_nxt;
      lamp_yellow  <= '0;
      phase_start  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multi_phase_controller.sv
// tb_multi_phase_controller: scoreboard bench with a phase-timeline reference model
module tb_multi_phase_controller;
  localparam int N = 4;
  localparam int TW = 7;
  logic clk = 1'b0;
  logic reset, enable, hold;
  logic [TW-1:0] green_time, yellow_time, allred_time;
  logic [N-1:0] skip_mask;
  logic [1:0] active_phase, sub_state;
  logic [TW-1:0] time_left;
  logic [N-1:0] lamp_green, lamp_yellow;
  logic phase_start;
  always #5 clk = ~clk;
  multi_phase_controller #(.NUM_PHASES(N), .TW(TW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold),
    .green_time(green_time), .yellow_time(yellow_time), .allred_time(allred_time),
    .skip_mask(skip_mask), .active_phase(active_phase), .sub_state(sub_state),
    .time_left(time_left), .lamp_green(lamp_green), .lamp_yellow(lamp_yellow),
    .phase_start(phase_start)
  );
  typedef struct packed {
    logic [1:0] st;
    logic [1:0] ph;
    logic [TW-1:0] tl;
    logic [N-1:0] lg;
    logic [N-1:0] ly;
    logic ps;
  } out_t;
  out_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int cyc_no = 0;
  // model: phase served, cycles elapsed inside it, and segment lengths fixed when each segment begins
  int m_run = 0, m_p = 0, m_e = 0, m_g = 0, m_y = 0, m_a = 0, m_start = 0;
  function automatic int mx1(int d);
    return d == 0 ? 1 : d;
  endfunction
  function automatic int next_phase(int p, logic [N-1:0] m);
    for (int k = 1; k <= N; k++) if (!m[(p + k) % N]) return (p + k) % N;
    return (p + 1) % N;
  endfunction
  function automatic out_t model_out();
    out_t o;
    int st, tl;
    st = !m_run ? 0 : m_e < m_g ? 1 : m_e < m_g + m_y ? 2 : 3;
    tl = st == 0 ? 0 : st == 1 ? m_g - 1 - m_e : st == 2 ? m_g + m_y - 1 - m_e : m_g + m_y + m_a - 1 - m_e;
    o.st = 2'(st);
    o.ph = 2'(m_p);
    o.tl = TW'(tl);
    o.lg = st == 1 ? N'(1) << m_p : '0;
    o.ly = st == 2 ? N'(1) << m_p : '0;
    o.ps = m_start != 0;
    return o;
  endfunction
  task automatic model_step();
    if (reset || !enable) begin
      m_run = 0; m_p = 0; m_e = 0; m_start = 0;
    end else if (m_run == 0) begin
      m_run = 1; m_p = 0; m_e = 0; m_g = mx1(int'(green_time)); m_start = 1;
    end else if (hold) begin
      m_start = 0;
    end else begin
      m_start = 0;
      m_e++;
      if (m_e == m_g) m_y = mx1(int'(yellow_time));
      if (m_e == m_g + m_y) m_a = int'(allred_time);
      if (m_e == m_g + m_y + m_a) begin
        m_p = next_phase(m_p, skip_mask);
        m_e = 0;
        m_g = mx1(int'(green_time));
        m_start = 1;
      end
    end
  endtask
  task automatic cyc();
    model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask
  task automatic run(int n);
    repeat (n) cyc();
  endtask
  task automatic wait_for(string name, int st, int ph, int tl, int budget);
    out_t o;
    int b;
    b = budget;
    o = model_out();
    while (b > 0 && !(int'(o.st) == st && (ph < 0 || int'(o.ph) == ph) && (tl < 0 || int'(o.tl) == tl))) begin
      cyc();
      b--;
      o = model_out();
    end
    if (b == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: condition not reached within %0d cycles, required st=%0d ph=%0d", name, budget, st, ph);
    end
  endtask
  // monitor: compare every registered output set against the oldest expectation
  always @(posedge clk) begin
    out_t e, a;
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{st: sub_state, ph: active_phase, tl: time_left, lg: lamp_green, ly: lamp_yellow, ps: phase_start};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs@cycle%0d: got st=%0d ph=%0d tl=%0d lg=%b ly=%b ps=%b, required st=%0d ph=%0d tl=%0d lg=%b ly=%b ps=%b",
                 cyc_no, a.st, a.ph, a.tl, a.lg, a.ly, a.ps, e.st, e.ph, e.tl, e.lg, e.ly, e.ps);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1; enable = 1'b0; hold = 1'b0;
    green_time = 7'd5; yellow_time = 7'd2; allred_time = 7'd1; skip_mask = 4'b0000;
    run(2);
    reset = 1'b0; enable = 1'b1;
    run(41);
    skip_mask = 4'b0110;
    run(32);
    skip_mask = 4'b0000; green_time = 7'd3; yellow_time = 7'd0; allred_time = 7'd0;
    run(20);
    green_time = 7'd5; yellow_time = 7'd2; allred_time = 7'd1;
    wait_for("hold_point", 1, -1, 2, 60);
    hold = 1'b1;
    run(10);
    hold = 1'b0;
    run(4);
    wait_for("yellow_ph2", 2, 2, -1, 100);
    hold = 1'b1; enable = 1'b0;
    run(3);
    enable = 1'b1; hold = 1'b0;
    run(10);
    skip_mask = 4'b1111;
    wait_for("allred_ph3", 3, 3, -1, 200);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(40);
    green_time = 7'd0; yellow_time = 7'd0; allred_time = 7'd0; skip_mask = 4'b0111;
    run(12);
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 99) == 0;
      enable = $urandom_range(0, 39) != 0;
      hold = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 15) == 0) skip_mask = N'($urandom);
      if ($urandom_range(0, 7) == 0) green_time = TW'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) yellow_time = TW'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) allred_time = TW'($urandom_range(0, 3));
      cyc();
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/multi_phase_controller.md
MULTI_PHASE_CONTROLLER -- requirements
Module: multi_phase_controller

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4, meaning number of conflicting signal phases, legal range 2..8.
REQ-002 SHALL have parameter TW, default 7, meaning width of all duration inputs and the countdown.
REQ-003 SHALL have parameter PW = $clog2(NUM_PHASES), derived, meaning phase index width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = run phase sequence; 0 = park in IDLE.
REQ-007 hold  input  1  1 = freeze countdown and state (manual/priority override).
REQ-008 green_time  input  TW  green duration in cycles.
REQ-009 yellow_time  input  TW  yellow duration in cycles.
REQ-010 allred_time  input  TW  all-red clearance duration in cycles; 0 = no clearance.
REQ-011 skip_mask  input  NUM_PHASES  bit i = 1: phase i has no demand and is skipped.
REQ-012 active_phase  output  PW  index of phase currently served.
REQ-013 sub_state  output  2  0 IDLE, 1 GREEN, 2 YELLOW, 3 ALLRED.
REQ-014 time_left  output  TW  cycles remaining in current sub_state minus 1.
REQ-015 lamp_green  output  NUM_PHASES  one-hot green lamp; all-zero when not GREEN.
REQ-016 lamp_yellow  output  NUM_PHASES  one-hot yellow lamp; all-zero when not YELLOW.
REQ-017 phase_start  output  1  one-cycle pulse in the first cycle of each GREEN.

Function
REQ-018 Durations SHALL be loaded as max(d,1)-1 into time_left, so green/yellow of 0 behave as 1 cycle.
REQ-019 In GREEN/YELLOW/ALLRED with hold=0 and time_left!=0, time_left SHALL decrement by 1 per cycle.
REQ-020 With hold=0 and time_left==0: GREEN->YELLOW (load yellow_time); YELLOW->ALLRED (load allred_time) if allred_time!=0, else directly to next GREEN; ALLRED->next GREEN.
REQ-021 Entering GREEN SHALL set active_phase to the next phase, load green_time and assert phase_start for that cycle only.
REQ-022 Next phase SHALL be the first index after active_phase, cyclically modulo NUM_PHASES, whose skip_mask bit is 0, sampled at the transition cycle.
REQ-023 If only the current phase is unmasked, next phase SHALL be the current phase (full GREEN/YELLOW/ALLRED cycle repeats).
REQ-024 If all skip_mask bits are 1, next phase SHALL be (active_phase+1) mod NUM_PHASES, no skipping.
REQ-025 Phase 0 SHALL be served first on leaving IDLE regardless of skip_mask.
REQ-026 In IDLE with enable=1 (hold ignored), next cycle SHALL enter GREEN of phase 0 with time_left=max(green_time,1)-1.
REQ-027 hold=1 SHALL freeze sub_state, active_phase, time_left and lamps; phase_start SHALL be 0 while held.
REQ-028 enable=0 SHALL, next cycle, force IDLE, active_phase=0, time_left=0, lamps all-zero, overriding hold and any transition.
REQ-029 Duration input changes SHALL affect only the next load, never a running countdown.
REQ-030 Total cycles per served phase SHALL equal max(g,1)+max(y,1)+a, a=allred_time.
REQ-031 lamp_green/lamp_yellow SHALL be registered, one-hot at bit active_phase, never both nonzero.

Reset
REQ-032 With reset=1 at a rising edge: sub_state=IDLE, active_phase=0, time_left=0, lamp_green=0, lamp_yellow=0, phase_start=0.
REQ-033 reset SHALL take priority over enable and hold, including mid-countdown; after release, IDLE rules apply (REQ-026).

Verification
REQ-034 N=4, g=5,y=2,a=1, mask=0, enable from reset: phase_start at cycle 1; GREEN time_left 4..0, YELLOW 1..0, ALLRED 0, phase 1 GREEN at cycle 9; phases 0,1,2,3,0 each 8 cycles.
REQ-035 mask=4'b0110, same durations: service order 0,3,0,3; phases 1,2 never lit.
REQ-036 a=0, g=3, y=0: GREEN 3 cycles, YELLOW 1 cycle, next GREEN immediately; 4 cycles/phase, no ALLRED observed.
REQ-037 hold=1 for 10 cycles at GREEN time_left=2: all outputs frozen 10 cycles, then countdown resumes 1,0 with no extra phase_start.
REQ-038 enable=0 during YELLOW of phase 2 with hold=1: next cycle IDLE, lamps 0, active_phase 0; re-enable restarts at phase 0 GREEN.
REQ-039 reset=1 mid-ALLRED of phase 3: next cycle all outputs at REQ-032 values; mask=4'b1111: order 0,1,2,3.
